// File: rtl/standoff_round_engine.sv
//------------------------------------------------------------------------------
// Module      : standoff_round_engine
// Description : Round controller for the standoff game. Owns both bullet
//               counters, requests a choice from simple_computer, resolves
//               each round and reports the winner.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module standoff_round_engine #(
    parameter int MAX_BULLETS  = 3,
    parameter int COMP_LATENCY = 2,
    parameter int HOLD_CYCLES  = 8,
    parameter int MAX_ROUNDS   = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p1_valid,
    input  logic [2:0] p1_choice,
    input  logic [2:0] comp_choice,
    output logic       load,
    output logic [1:0] p1_bullet,
    output logic [1:0] comp_bullet,
    output logic [2:0] last_p1,
    output logic [2:0] last_comp,
    output logic       round_done,
    output logic [3:0] round_count,
    output logic [1:0] winner,
    output logic       game_over,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_RESOLVE = 3'd3,
        S_HOLD    = 3'd4,
        S_OVER    = 3'd5
    } state_e;

    localparam int             CNT_W       = 16;
    localparam logic [2:0]     C_RELOAD    = 3'd1;
    localparam logic [2:0]     C_SHOOT     = 3'd2;
    localparam logic [2:0]     C_BLOCK     = 3'd3;
    localparam logic [1:0]     C_MAX_B     = 2'(MAX_BULLETS);
    localparam logic [3:0]     C_MAX_R     = 4'(MAX_ROUNDS);
    localparam logic [CNT_W-1:0] C_WAIT_LAST = CNT_W'(COMP_LATENCY - 1);
    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       p1_act_q, p1_act_d;
    logic [2:0]       comp_act_q, comp_act_d;
    logic [1:0]       p1_bullet_q, p1_bullet_d;
    logic [1:0]       comp_bullet_q, comp_bullet_d;
    logic [2:0]       last_p1_q, last_p1_d;
    logic [2:0]       last_comp_q, last_comp_d;
    logic             round_done_q, round_done_d;
    logic [3:0]       round_count_q, round_count_d;
    logic [1:0]       winner_q, winner_d;

    logic [2:0]       w_p_eff;
    logic [2:0]       w_c_eff;
    logic             w_p_hit;
    logic             w_c_hit;
    logic [3:0]       w_round_inc;

    // Illegal codes become BLOCK; a shot with an empty gun also becomes BLOCK.
    function automatic logic [2:0] effective_action(input logic [2:0] act,
                                                    input logic [1:0] bullets);
        if (act == C_RELOAD)
            return C_RELOAD;
        if (act == C_SHOOT && bullets != 2'd0)
            return C_SHOOT;
        return C_BLOCK;
    endfunction

    assign w_p_eff     = effective_action(p1_act_q, p1_bullet_q);
    assign w_c_eff     = effective_action(comp_act_q, comp_bullet_q);
    assign w_p_hit     = (w_c_eff == C_SHOOT) && (w_p_eff == C_RELOAD);
    assign w_c_hit     = (w_p_eff == C_SHOOT) && (w_c_eff == C_RELOAD);
    assign w_round_inc = (round_count_q == 4'hF) ? round_count_q : round_count_q + 4'd1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        p1_act_d      = p1_act_q;
        comp_act_d    = comp_act_q;
        p1_bullet_d   = p1_bullet_q;
        comp_bullet_d = comp_bullet_q;
        last_p1_d     = last_p1_q;
        last_comp_d   = last_comp_q;
        round_done_d  = 1'b0;
        round_count_d = round_count_q;
        winner_d      = winner_q;

        case (state_q)
            S_IDLE: begin
                if (p1_valid) begin
                    p1_act_d = p1_choice;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == C_WAIT_LAST) begin
                    comp_act_d = comp_choice;
                    state_d    = S_RESOLVE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESOLVE: begin
                if (w_p_eff == C_RELOAD && p1_bullet_q < C_MAX_B)
                    p1_bullet_d = p1_bullet_q + 2'd1;
                else if (w_p_eff == C_SHOOT)
                    p1_bullet_d = p1_bullet_q - 2'd1;

                if (w_c_eff == C_RELOAD && comp_bullet_q < C_MAX_B)
                    comp_bullet_d = comp_bullet_q + 2'd1;
                else if (w_c_eff == C_SHOOT)
                    comp_bullet_d = comp_bullet_q - 2'd1;

                last_p1_d     = w_p_eff;
                last_comp_d   = w_c_eff;
                round_count_d = w_round_inc;
                round_done_d  = 1'b1;
                cnt_d         = '0;

                if (w_p_hit)
                    winner_d = 2'b10;
                else if (w_c_hit)
                    winner_d = 2'b01;
                else if (w_round_inc == C_MAX_R)
                    winner_d = 2'b11;
                else
                    winner_d = 2'b00;

                state_d = (winner_d != 2'b00) ? S_OVER : S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q == C_HOLD_LAST)
                    state_d = S_IDLE;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            p1_act_q      <= 3'd0;
            comp_act_q    <= 3'd0;
            p1_bullet_q   <= 2'd0;
            comp_bullet_q <= 2'd0;
            last_p1_q     <= 3'd0;
            last_comp_q   <= 3'd0;
            round_done_q  <= 1'b0;
            round_count_q <= 4'd0;
            winner_q      <= 2'b00;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            p1_act_q      <= p1_act_d;
            comp_act_q    <= comp_act_d;
            p1_bullet_q   <= p1_bullet_d;
            comp_bullet_q <= comp_bullet_d;
            last_p1_q     <= last_p1_d;
            last_comp_q   <= last_comp_d;
            round_done_q  <= round_done_d;
            round_count_q <= round_count_d;
            winner_q      <= winner_d;
        end
    end

    assign load        = (state_q == S_REQ);
    assign busy        = (state_q != S_IDLE);
    assign game_over   = (state_q == S_OVER);
    assign p1_bullet   = p1_bullet_q;
    assign comp_bullet = comp_bullet_q;
    assign last_p1     = last_p1_q;
    assign last_comp   = last_comp_q;
    assign round_done  = round_done_q;
    assign round_count = round_count_q;
    assign winner      = winner_q;

endmodule

`default_nettype wire

// File: doc/standoff_round_engine.md
Name: standoff_round_engine

Overview:
- Round controller for the standoff game; sits around simple_computer.
- Upstream role: owns both bullet counters and drives simple_computer's load, p1_bullet and comp_bullet.
- Downstream role: consumes the computer's 3-bit choice, resolves each round against the player's latched action, and reports the winner to display logic.

Parameters:
- MAX_BULLETS, 3: saturation limit of each bullet counter; must be ≤ 3.
- COMP_LATENCY, 2: cycles from the end of the load pulse until comp_choice is sampled; must be ≥ 1.
- HOLD_CYCLES, 8: cycles the round result is held before a new action is accepted; must be ≥ 1.
- MAX_ROUNDS, 15: round count at which an unresolved game ends as a draw.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- p1_valid  input  1  one-cycle pulse: the player has committed an action.
- p1_choice  input  3  player action.
- comp_choice  input  3  choice output of simple_computer.
- load  output  1  one-cycle request to simple_computer.
- p1_bullet  output  2  player bullet count; feeds simple_computer.
- comp_bullet  output  2  computer bullet count; feeds simple_computer.
- last_p1  output  3  player action as resolved in the last round.
- last_comp  output  3  computer action as resolved in the last round.
- round_done  output  1  one-cycle pulse after each resolution.
- round_count  output  4  completed rounds, saturating at 15.
- winner  output  2  00 none, 01 player, 10 computer, 11 draw.
- game_over  output  1  sticky until reset.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Action codes:
  - 3'd1 RELOAD, 3'd2 SHOOT, 3'd3 BLOCK.
  - Any other code (0, 4-7) resolves as BLOCK.
  - last_p1 and last_comp hold the normalized code.
- Reset (synchronous): state IDLE; load=0, p1_bullet=0, comp_bullet=0, last_p1=0, last_comp=0, round_done=0, round_count=0, winner=00, game_over=0, busy=0. Reset asserted in any state, including WAIT or HOLD, aborts the round on the next edge.
- FSM states: IDLE, REQ, WAIT, RESOLVE, HOLD, OVER.
- IDLE:
  - busy=0.
  - On p1_valid=1: latch p1_choice, go to REQ.
  - p1_valid is ignored in every other state; no queuing.
- REQ: load=1 for exactly this cycle; go to WAIT.
- WAIT:
  - Counter runs COMP_LATENCY cycles.
  - On the last WAIT cycle, latch comp_choice; go to RESOLVE.
- RESOLVE (one cycle) computes the round result; all registered outputs change together on the exit edge.
  - Dry fire: SHOOT with own bullet count 0 is treated as BLOCK, and no bullet is consumed.
  - RELOAD: own count +1, saturating at MAX_BULLETS (no wrap from 3 to 0).
  - SHOOT (effective): own count −1.
  - Both SHOOT: both decrement, no hit (cancel).
  - SHOOT vs RELOAD: the shooter wins.
  - SHOOT vs BLOCK: no hit.
  - Player hit → winner=10. Computer hit → winner=01.
  - round_count increments, saturating at 15.
  - If no hit and the new round_count equals MAX_ROUNDS → winner=11.
  - round_done pulses 1 on the cycle after RESOLVE.
  - Next state: OVER if winner≠00, else HOLD.
- HOLD:
  - Counter runs HOLD_CYCLES cycles, then go to IDLE.
  - Outputs are held.
- OVER:
  - game_over=1; all outputs frozen.
  - Only reset exits.
- Latency: p1_valid seen at edge N → load high N+1 → round_done high at edge N+3+COMP_LATENCY.
- The bullet count changes from one round are visible to simple_computer before its next load pulse.

Test Plan:
- Reset then idle → all outputs 0; no load pulse while p1_valid=0 for 50 cycles.
- Player RELOAD, computer RELOAD, repeated 4 times → p1_bullet=comp_bullet=3 (saturated, no wrap); round_count=4; winner=00; 4 load pulses, each exactly 1 cycle wide.
- p1_bullet=1, player SHOOT vs computer RELOAD → winner=01, game_over=1, p1_bullet=0; a further p1_valid produces no load.
- Player SHOOT with p1_bullet=0 vs computer SHOOT with comp_bullet=1 → player dry-fires (resolves as BLOCK), comp_bullet=0, winner=00, last_p1=3.
- Both at 1 bullet, both SHOOT → both 0, no winner. Also: p1_choice=7 vs computer SHOOT → resolves as block, winner=00.
- Reset asserted during WAIT → next edge load=0 and busy=0, counters 0. Separately: 15 rounds of BLOCK/BLOCK → winner=11, game_over=1.
